// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types for the UART receiver / LED display slice.
// Holds the receiver FSM states, parity and display-mode codes, divisor helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [1:0] MODE_DATA  = 2'd0;
  localparam logic [1:0] MODE_COUNT = 2'd1;
  localparam logic [1:0] MODE_ERR   = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  // Clocks per oversample tick, truncated, never below 1.
  function automatic int calc_div(
    input int clk_hz,
    input int baud,
    input int os
  );
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick divider, one-clock o_tick every DIV clocks.
// Ports: i_clk, i_rst_n (sync, active-low), i_hold (forces count to 0), o_tick.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_hold,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_hold) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = !i_hold && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_led_ctrl.sv
// uart_rx_led_ctrl: oversampling UART receiver with sticky errors and LED view.
// Ports: clk/rst_n/rxd/btn/mode/err_clr pins in; led, rx_data, rdy, errors out.
module uart_rx_led_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int LED_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_pin,
  input  logic                 rst_n_pin,
  input  logic                 rxd_pin,
  input  logic                 btn_pin,
  input  logic [1:0]           mode_pin,
  input  logic                 err_clr_pin,
  output logic [LED_W-1:0]     led_pins,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_data_rdy_out,
  output logic                 frame_err_out,
  output logic                 parity_err_out
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = 4;
  localparam int H   = LED_W / 2;
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  rx_state_e r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_rxd_sync, r_btn_sync;
  logic [TW-1:0]          r_tcnt;
  logic [BW-1:0]          r_bit;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_pbad;
  logic [LED_W-1:0]       r_count;

  logic             w_rxd, w_btn, w_hold, w_tick, w_samp;
  logic             w_valid, w_perr_set, w_ferr_set, w_par_bad;
  logic [TW-1:0]    w_target;
  logic [LED_W-1:0] w_word, w_led;

  assign w_rxd  = r_rxd_sync[SYNC_STAGES-1];
  assign w_btn  = r_btn_sync[SYNC_STAGES-1];
  assign w_hold = (r_state == ST_IDLE);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .i_clk  (clk_pin),
    .i_rst_n(rst_n_pin),
    .i_hold (w_hold),
    .o_tick (w_tick)
  );

  // rxd synchroniser clears to the idle line level so reset
  // cannot fabricate a start edge.
  always_ff @(posedge clk_pin) begin
    if (!rst_n_pin) begin
      r_rxd_sync <= '1;
      r_btn_sync <= '0;
    end else begin
      r_rxd_sync <= SYNC_STAGES'({r_rxd_sync, rxd_pin});
      r_btn_sync <= SYNC_STAGES'({r_btn_sync, btn_pin});
    end
  end

  always_ff @(posedge clk_pin) begin
    if (!rst_n_pin) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Start bit is re-checked half a bit in; later samples are bit-centred.
  assign w_target = (r_state == ST_START) ? T_HALF : T_FULL;
  assign w_samp   = w_tick && (r_tcnt == w_target);

  assign w_par_bad = (PARITY == PARITY_EVEN) ?
                     (^r_shift ^ w_rxd) : ~(^r_shift ^ w_rxd);

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_perr_set  = 1'b0;
    w_ferr_set  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_rxd) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_samp) w_state_nxt = w_rxd ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_samp && r_bit == B_LAST)
          w_state_nxt = (PARITY != PARITY_NONE) ?
                        ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_samp) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_samp) begin
          if (!w_rxd) begin
            w_ferr_set  = 1'b1;
            w_state_nxt = ST_BREAK;
          end else begin
            w_state_nxt = ST_IDLE;
            w_perr_set  = r_pbad;
            w_valid     = !r_pbad;
          end
        end
      end
      ST_BREAK: begin
        if (w_rxd) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_word = LED_W'(rx_data_out);

  always_comb begin
    w_led = w_word;
    unique case (mode_pin)
      MODE_COUNT: w_led = r_count;
      MODE_ERR:   w_led = LED_W'({parity_err_out, frame_err_out});
      MODE_DATA, MODE_RSVD: begin
        if (w_btn) w_led = {w_word[H-1:0], w_word[LED_W-1:H]};
      end
    endcase
  end

  always_ff @(posedge clk_pin) begin
    if (!rst_n_pin) begin
      r_tcnt          <= '0;
      r_bit           <= '0;
      r_shift         <= '0;
      r_pbad          <= 1'b0;
      r_count         <= '0;
      rx_data_out     <= '0;
      rx_data_rdy_out <= 1'b0;
      frame_err_out   <= 1'b0;
      parity_err_out  <= 1'b0;
      led_pins        <= '0;
    end else begin
      rx_data_rdy_out <= w_valid;
      led_pins        <= w_led;
      // Tick count restarts whenever no frame is in progress.
      if (r_state == ST_IDLE || r_state == ST_BREAK)
        r_tcnt <= '0;
      else if (w_tick)
        r_tcnt <= w_samp ? '0 : r_tcnt + TW'(1);
      if (r_state == ST_START) begin
        r_bit  <= '0;
        r_pbad <= 1'b0;
      end
      if (r_state == ST_DATA && w_samp) begin
        r_shift <= {w_rxd, r_shift[DATA_BITS-1:1]};
        r_bit   <= r_bit + BW'(1);
      end
      if (r_state == ST_PARITY && w_samp)
        r_pbad <= w_par_bad;
      if (w_valid) begin
        rx_data_out <= r_shift;
        r_count     <= r_count + LED_W'(1);
      end
      frame_err_out  <= w_ferr_set |
                        (frame_err_out & ~err_clr_pin);
      parity_err_out <= w_perr_set |
                        (parity_err_out & ~err_clr_pin);
    end
  end

endmodule

// File: tb/tb_uart_rx_led_ctrl.sv
// tb_uart_rx_led_ctrl: self-checking bench, default 8N1 instance plus a
// fast even-parity instance for parity, set-wins and count-wrap cases.
module tb_uart_rx_led_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst_n_p, rxd, rxd_p, btn, err_clr;
  logic [1:0] mode;

  logic [7:0] led0, data0, led_p, data_p;
  logic       rdy0, ferr0, perr0, rdy_p, ferr_p, perr_p;

  int checks = 0;
  int failures = 0;
  int rdy_cnt0 = 0;
  int rdy_cntp = 0;

  logic [7:0] q0[$];
  logic [7:0] qp[$];
  logic       led_pend = 1'b0;
  logic [7:0] led_exp;
  logic [7:0] e0, ep;

  typedef struct {
    logic       btn;
    logic [1:0] mode;
    logic [7:0] exp;
  } led_vec_t;
  led_vec_t tbl[6];

  uart_rx_led_ctrl dut (
    .clk_pin        (clk),
    .rst_n_pin      (rst_n),
    .rxd_pin        (rxd),
    .btn_pin        (btn),
    .mode_pin       (mode),
    .err_clr_pin    (err_clr),
    .led_pins       (led0),
    .rx_data_out    (data0),
    .rx_data_rdy_out(rdy0),
    .frame_err_out  (ferr0),
    .parity_err_out (perr0)
  );

  uart_rx_led_ctrl #(
    .BAUD      (6250000),
    .OVERSAMPLE(8),
    .PARITY    (2)
  ) dutp (
    .clk_pin        (clk),
    .rst_n_pin      (rst_n_p),
    .rxd_pin        (rxd_p),
    .btn_pin        (btn),
    .mode_pin       (mode),
    .err_clr_pin    (err_clr),
    .led_pins       (led_p),
    .rx_data_out    (data_p),
    .rx_data_rdy_out(rdy_p),
    .frame_err_out  (ferr_p),
    .parity_err_out (perr_p)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w, input logic v);
    if (w) rxd_p = v;
    else   rxd   = v;
  endtask

  task automatic send_frame(input bit w, input logic [8:0] d,
                            input int nb, input bit has_p,
                            input bit pb, input bit stop,
                            input int stop_len, input int cpb);
    drive(w, 1'b0);
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      drive(w, d[i]);
      repeat (cpb) @(negedge clk);
    end
    if (has_p) begin
      drive(w, pb);
      repeat (cpb) @(negedge clk);
    end
    drive(w, stop);
    repeat (cpb * stop_len) @(negedge clk);
    drive(w, 1'b1);
  endtask

  task automatic wait_empty(input bit w, input int budget);
    int n = 0;
    while (((w ? qp.size() : q0.size()) != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(w ? "sb_drain_p" : "sb_drain0",
        w ? qp.size() : q0.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rdy0) begin
      rdy_cnt0++;
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdy0_unexpected got=%0h exp=none", data0);
      end else begin
        e0 = q0.pop_front();
        chk("rx_data0", data0, e0);
        led_pend = 1'b1;
        led_exp  = e0;
      end
    end else if (led_pend) begin
      led_pend = 1'b0;
      if (mode == 2'd0 && !btn) chk("led0_after_rdy", led0, led_exp);
    end
  end

  always @(negedge clk) begin
    if (rdy_p) begin
      rdy_cntp++;
      if (qp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdy_p_unexpected got=%0h exp=none", data_p);
      end else begin
        ep = qp.pop_front();
        chk("rx_data_p", data_p, ep);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] w;
    int n;
    tbl[0] = '{1'b0, 2'd0, 8'hA5};
    tbl[1] = '{1'b1, 2'd0, 8'h5A};
    tbl[2] = '{1'b1, 2'd3, 8'h5A};
    tbl[3] = '{1'b0, 2'd3, 8'hA5};
    tbl[4] = '{1'b1, 2'd1, 8'h01};
    tbl[5] = '{1'b1, 2'd2, 8'h00};

    rst_n = 0; rst_n_p = 0; rxd = 1; rxd_p = 1;
    btn = 0; mode = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_led0", led0, 0);
    chk("rst_data0", data0, 0);
    chk("rst_rdy0", rdy0, 0);
    chk("rst_ferr0", ferr0, 0);
    chk("rst_perr0", perr0, 0);
    chk("rst_led_p", led_p, 0);
    rst_n = 1; rst_n_p = 1;
    repeat (5) @(negedge clk);

    q0.push_back(8'hA5);
    send_frame(0, 9'h0A5, 8, 0, 0, 1, 1, 432);
    wait_empty(0, 2000);
    repeat (5) @(negedge clk);
    chk("rdy_cnt_a5", rdy_cnt0, 1);

    for (int i = 0; i < 6; i++) begin
      btn  = tbl[i].btn;
      mode = tbl[i].mode;
      repeat (5) @(negedge clk);
      chk($sformatf("led_vec%0d", i), led0, tbl[i].exp);
    end
    btn = 0; mode = 0;
    repeat (5) @(negedge clk);

    rxd = 0;
    repeat (100) @(negedge clk);
    rxd = 1;
    repeat (600) @(negedge clk);
    chk("false_start_rdy", rdy_cnt0, 1);
    chk("false_start_ferr", ferr0, 0);
    chk("false_start_perr", perr0, 0);
    q0.push_back(8'h3C);
    send_frame(0, 9'h03C, 8, 0, 0, 1, 1, 432);
    wait_empty(0, 2000);
    repeat (5) @(negedge clk);
    chk("rdy_cnt_3c", rdy_cnt0, 2);

    send_frame(0, 9'h055, 8, 0, 0, 0, 2, 432);
    repeat (50) @(negedge clk);
    chk("ferr_set", ferr0, 1);
    chk("ferr_no_rdy", rdy_cnt0, 2);
    chk("ferr_data_kept", data0, 8'h3C);
    chk("ferr_led_kept", led0, 8'h3C);
    mode = 2;
    repeat (5) @(negedge clk);
    chk("led_mode2", led0, 8'h01);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    repeat (3) @(negedge clk);
    chk("ferr_cleared", ferr0, 0);
    chk("led_mode2_clr", led0, 8'h00);
    mode = 0;
    repeat (5) @(negedge clk);

    w = 8'h5A;
    rxd = 0;
    repeat (432) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = w[i];
      repeat (432) @(negedge clk);
    end
    rxd = w[3];
    repeat (200) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    rxd = 1;
    chk("midrst_led", led0, 0);
    chk("midrst_data", data0, 0);
    chk("midrst_rdy", rdy0, 0);
    chk("midrst_ferr", ferr0, 0);
    repeat (864) @(negedge clk);
    chk("midrst_no_rdy", rdy_cnt0, 2);
    q0.push_back(8'hC3);
    send_frame(0, 9'h0C3, 8, 0, 0, 1, 1, 432);
    wait_empty(0, 2000);
    repeat (5) @(negedge clk);
    mode = 1;
    repeat (5) @(negedge clk);
    chk("count_after_rst", led0, 8'h01);
    mode = 0;
    repeat (5) @(negedge clk);

    send_frame(1, 9'h003, 8, 1, 1, 1, 1, 8);
    repeat (10) @(negedge clk);
    chk("perr_set", perr_p, 1);
    chk("perr_no_rdy", rdy_cntp, 0);
    chk("perr_no_ferr", ferr_p, 0);
    qp.push_back(8'h07);
    send_frame(1, 9'h007, 8, 1, 1, 1, 1, 8);
    wait_empty(1, 200);
    repeat (5) @(negedge clk);
    chk("par_ok_rdy", rdy_cntp, 1);
    chk("perr_sticky", perr_p, 1);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    repeat (3) @(negedge clk);
    chk("perr_cleared", perr_p, 0);

    err_clr = 1;
    n = 0;
    fork
      send_frame(1, 9'h003, 8, 1, 1, 1, 1, 8);
      begin
        repeat (110) begin
          @(negedge clk);
          if (perr_p) n++;
        end
      end
    join
    err_clr = 0;
    chk("perr_set_wins_cycles", n, 1);

    rst_n_p = 0;
    @(negedge clk);
    rst_n_p = 1;
    mode = 1;
    repeat (3) @(negedge clk);
    chk("count_rst_p", led_p, 0);
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom_range(0, 255));
      qp.push_back(w);
      send_frame(1, {1'b0, w}, 8, 1, ^w, 1, 1, 8);
      repeat (2) @(negedge clk);
      if (i == 2) begin
        repeat (3) @(negedge clk);
        chk("count3", led_p, 8'h03);
      end
    end
    wait_empty(1, 200);
    repeat (3) @(negedge clk);
    chk("count_wrap", led_p, 8'h00);
    chk("rdy_cnt_p_total", rdy_cntp, 257);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_led_ctrl.md
Name: uart_rx_led_ctrl

Overview:
Parametrised UART receiver with LED display control, for the PL-side hardware-debug path. Its RXD input is driven by PS GPIO or an external pin. It oversamples the serial line, validates framing and optional parity, and reports each received word with a one-cycle ready pulse (an ILA probe point). It drives the LEDs in one of three display modes: last word with optional half-swap, received-word count, or sticky error flags.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz
BAUD, 115200, line baud rate
OVERSAMPLE, 16, sample ticks per bit; even, >=8
DATA_BITS, 8, data bits per frame; 5..9
PARITY, 0, 0=none, 1=odd, 2=even
LED_W, 8, LED output width; >=DATA_BITS, even
SYNC_STAGES, 2, metastability flops on rxd_pin and btn_pin

Ports:
clk_pin  in  1  system clock
rst_n_pin  in  1  reset, synchronous, active-low
rxd_pin  in  1  serial RX line, idle high, asynchronous
btn_pin  in  1  asynchronous; held high swaps upper/lower LED halves in mode 0
mode_pin  in  2  display mode: 0=data, 1=count, 2=errors, 3=reserved (behaves as 0)
err_clr_pin  in  1  synchronous clear of sticky error flags
led_pins  out  LED_W  LED drive
rx_data_out  out  DATA_BITS  last valid received word
rx_data_rdy_out  out  1  one-cycle pulse per valid word
frame_err_out  out  1  sticky framing error
parity_err_out  out  1  sticky parity error

Behaviour:
- Reset (rst_n_pin low at a clk_pin edge): all outputs 0; FSM to IDLE; tick divider, byte counter and synchronisers cleared. Reset mid-frame abandons the frame with no partial output.
- Tick generator: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), truncated, minimum 1. Counts 0..DIV-1 and emits a one-clock tick at wrap. Free-running except in IDLE, where it is held at 0 so the first tick aligns with the start edge.
- rxd_pin and btn_pin each pass through SYNC_STAGES flops before use.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE -> START on synchronised rxd = 0.
  - START: after OVERSAMPLE/2 ticks, re-sample. If 1: false start, back to IDLE with no flags. If 0: go to DATA.
  - DATA: sample every OVERSAMPLE ticks, LSB first, DATA_BITS samples. Then go to PARITY if PARITY != 0, else STOP.
  - PARITY: one sample. A mismatch is latched internally.
  - STOP: one sample. If 1 and parity OK: word is valid, go to IDLE. If 1 and parity bad: set parity_err_out, discard word, go to IDLE. If 0: set frame_err_out, discard word, go to BREAK.
  - BREAK: wait for synchronised rxd = 1, then IDLE.
- Valid word timing: rx_data_out and rx_data_rdy_out are registered on the clk edge after the stop-sample tick. rx_data_rdy_out is high for exactly one cycle. On the same edge the count increments modulo 2^LED_W.
- LED update, one cycle after the rdy pulse for mode 0. Mode/btn changes take effect one cycle after synchronisation.
  - mode 0: word zero-extended to LED_W. With btn high, upper and lower LED_W/2 halves are swapped.
  - mode 1: count.
  - mode 2: {0..., parity_err_out, frame_err_out}.
- Error flags are sticky. err_clr_pin clears them on the next edge. If a new error sets in the same cycle as err_clr, set wins.
- Rx continues uninterrupted during mode changes and err_clr. There is no overrun condition: the output register is overwritten by each valid word.

Decomposition:
- Package uart_rx_pkg:
  - FSM state enum
  - PARITY_NONE/ODD/EVEN constants
  - MODE_DATA/COUNT/ERR constants
  - divisor calculation function
- Sub-module uart_baud_tick: parametrised tick divider with hold input.

Test Plan:
- Defaults (DIV=27, 432 clk/bit): send 0xA5 8N1 -> single rdy pulse, rx_data_out=0xA5, led_pins=0xA5 one cycle later. Raise btn -> led_pins=0x5A.
- rxd low for 100 clks then high (shorter than half-bit 216) -> no rdy, no flags, FSM IDLE. A following 0x3C is received correctly.
- Send 0x55 with stop bit 0, held low 2 bit-times -> frame_err_out=1, no rdy, rx_data_out and LEDs unchanged. In mode 2, led_pins=0x01. Pulse err_clr -> 0.
- PARITY=2: send 0x03 with parity bit 1 -> parity_err_out=1, no rdy. Send 0x07 with parity 1 -> rdy, rx_data_out=0x07.
- Mode 1: send 3 words -> led_pins=0x03. Send 253 more -> led_pins=0x00 (wrap).
- Drop rst_n_pin for 1 cycle during data bit 3 -> all outputs 0 next edge. The next frame 0xC3 is received correctly.
